// File: rtl/clk_div_monitor_pkg.sv
// Shared types and default parameters for the divided-clock monitor.
package clk_div_monitor_pkg;

  localparam int DEF_DIV      = 7;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_TIMEOUT  = 32;
  localparam int DEF_CW       = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // A period is good when its length matches the divide ratio and the high
  // time is within half a cycle of 50% (either half of an odd ratio is fine).
  function automatic logic period_good(input int unsigned per,
                                       input int unsigned hi,
                                       input int unsigned div);
    return (per == div) && (hi >= div / 2) && (hi <= (div + 1) / 2);
  endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Signal bundle between the monitor and its consumer.
// Protocol: period_valid is a one-cycle qualifier for period/high_cnt with no
// backpressure (there is no ready); lock and timeout are levels, err is a
// one-cycle pulse. state is a debug view of the monitor FSM.
interface clk_div_monitor_if
  import clk_div_monitor_pkg::*;
#(
  parameter int CW = DEF_CW
) ();

  logic          div_clk;
  logic [CW-1:0] period;
  logic [CW-1:0] high_cnt;
  logic          period_valid;
  logic          lock;
  logic          err;
  logic          timeout;
  state_t        state;

  modport master (
    input  div_clk,
    output period, high_cnt, period_valid, lock, err, timeout, state
  );

  modport slave (
    output div_clk,
    input  period, high_cnt, period_valid, lock, err, timeout, state
  );

endinterface

// File: rtl/clk_div_monitor_edge_sync.sv
// Two-flop synchronizer for div_clk plus one history flop for rise detection.
module edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  // Shift the asynchronous input through two sync stages and a history stage.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~hist_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of div_clk in clk_in cycles, declares lock
// after LOCK_CNT consecutive good periods, flags bad periods while locked and
// declares loss when no rise is seen for TIMEOUT cycles.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int DIV      = DEF_DIV,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CW       = DEF_CW
) (
  input logic              clk_in,
  input logic              rst,
  clk_div_monitor_if.master bus
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  logic          sync_level;
  logic          rise;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] hcnt_q;
  logic [GW-1:0] good_q;
  logic [CW-1:0] period_q;
  logic [CW-1:0] high_q;
  logic          pv_q;
  logic          lock_q;
  logic          err_q;
  logic          timeout_q;
  logic          cur_good;
  logic          at_timeout;

  edge_sync u_edge_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .din    (bus.div_clk),
    .level  (sync_level),
    .rise   (rise)
  );

  assign cur_good   = period_good(32'(cnt_q), 32'(hcnt_q), DIV);
  assign at_timeout = (32'(cnt_q) == 32'(TIMEOUT));

  // Counters (restart at 1 on a rise so the rise cycle itself is counted)
  // and the monitor FSM with all of its registered outputs.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      good_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      pv_q      <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pv_q  <= 1'b0;
      err_q <= 1'b0;
      if (rise) begin
        cnt_q  <= CW'(1);
        hcnt_q <= CW'(1);
        case (state_q)
          IDLE: begin
            state_q   <= MEASURE;
            timeout_q <= 1'b0;
            good_q    <= '0;
          end
          MEASURE: begin
            period_q <= cnt_q;
            high_q   <= hcnt_q;
            pv_q     <= 1'b1;
            if (!cur_good) begin
              good_q <= '0;
            end else if (good_q != GW'(LOCK_CNT)) begin
              good_q <= good_q + 1'b1;
            end
          end
          LOCKED: begin
            period_q <= cnt_q;
            high_q   <= hcnt_q;
            pv_q     <= 1'b1;
            if (!cur_good) begin
              state_q <= MEASURE;
              err_q   <= 1'b1;
              lock_q  <= 1'b0;
              good_q  <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else begin
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (sync_level && (hcnt_q != '1)) begin
          hcnt_q <= hcnt_q + 1'b1;
        end
        if ((state_q != IDLE) && at_timeout) begin
          state_q   <= IDLE;
          lock_q    <= 1'b0;
          timeout_q <= 1'b1;
          good_q    <= '0;
        end else if ((state_q == MEASURE) && (good_q >= GW'(LOCK_CNT))) begin
          state_q <= LOCKED;
          lock_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.high_cnt     = high_q;
  assign bus.period_valid = pv_q;
  assign bus.lock         = lock_q;
  assign bus.err          = err_q;
  assign bus.timeout      = timeout_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios plus randomized periods,
// every cycle compared against an edge-indexed behavioural model.
module tb_clk_div_monitor;
  import clk_div_monitor_pkg::*;

  localparam int DIV      = 7;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 32;
  localparam int CW       = 8;
  localparam int SAT      = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  always #5 clk_in = ~clk_in;

  clk_div_monitor_if #(.CW(CW)) bus ();

  clk_div_monitor #(
    .DIV(DIV), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  int chk_cnt  = 0;
  int fail_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      fail_cnt++;
      if (fail_cnt <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // raw_q[k] is div_clk as seen at posedge k. A rise is acted on at edge j
  // when sample j-2 is high and sample j-3 is low; period is the edge distance
  // between acted-on rises; high time is the number of high samples delayed
  // by the same two edges inside that interval.
  bit raw_q[$];
  int rel_edge  = 0;
  int edge_idx  = 0;
  bit m_active  = 0;
  bit m_locked  = 0;
  int last_rise = 0;
  int good      = 0;
  int m_period  = 0;
  int m_high    = 0;
  bit m_pv = 0, m_lock = 0, m_err = 0, m_to = 0;

  function automatic bit smp(input int i);
    return (i >= rel_edge && i >= 0) ? raw_q[i] : 1'b0;
  endfunction

  // observation record for hand-computed checks
  int pv_cnt = 0, err_cnt = 0, to_cnt = 0, lock_rises = 0;
  int last_pv_period = 0, last_pv_edge = 0, err_period = 0, err_high = 0;
  int to_edge = 0, to_lock = 0, err_lock = 0, lock_gap = 0, lock_pv = 0;
  bit to_prev = 0, lock_prev = 0;

  // Model step and per-cycle comparison
  always @(posedge clk_in) begin
    int e;
    bit rise_now;
    int hs;
    int exp_state;
    raw_q.push_back(bus.div_clk);
    e = raw_q.size() - 1;
    edge_idx = e;
    m_pv = 0;
    m_err = 0;
    if (!rst) begin
      m_active = 0; m_locked = 0; good = 0; m_period = 0; m_high = 0;
      m_lock = 0; m_to = 0;
      rel_edge = e + 1;
    end else begin
      rise_now = smp(e - 2) && !smp(e - 3);
      if (rise_now) begin
        if (!m_active) begin
          m_active = 1; m_locked = 0; good = 0; m_to = 0;
        end else begin
          hs = 0;
          for (int i = last_rise; i < e; i++) hs += int'(smp(i - 2));
          m_period = (e - last_rise > SAT) ? SAT : e - last_rise;
          m_high   = (hs > SAT) ? SAT : hs;
          m_pv     = 1;
          if (m_locked) begin
            if (!(m_period == DIV && m_high >= DIV / 2 && m_high <= (DIV + 1) / 2)) begin
              m_err = 1; m_locked = 0; m_lock = 0; good = 0;
            end
          end else if (m_period == DIV && m_high >= DIV / 2 && m_high <= (DIV + 1) / 2) begin
            good++;
          end else begin
            good = 0;
          end
        end
        last_rise = e;
      end else if (m_active && (e - last_rise == TIMEOUT)) begin
        m_active = 0; m_locked = 0; m_lock = 0; m_to = 1; good = 0;
      end else if (m_active && !m_locked && good >= LOCK_CNT) begin
        m_locked = 1; m_lock = 1;
      end
    end
    exp_state = !m_active ? int'(IDLE) : (m_locked ? int'(LOCKED) : int'(MEASURE));
    #1;
    check("period", int'(bus.period), m_period);
    check("high_cnt", int'(bus.high_cnt), m_high);
    check("period_valid", int'(bus.period_valid), int'(m_pv));
    check("lock", int'(bus.lock), int'(m_lock));
    check("err", int'(bus.err), int'(m_err));
    check("timeout", int'(bus.timeout), int'(m_to));
    check("state", int'(bus.state), exp_state);
    if (bus.period_valid) begin
      pv_cnt++; last_pv_period = int'(bus.period); last_pv_edge = e;
    end
    if (bus.err) begin
      err_cnt++; err_period = int'(bus.period); err_high = int'(bus.high_cnt);
      err_lock = int'(bus.lock);
    end
    if (bus.timeout && !to_prev) begin
      to_cnt++; to_edge = e; to_lock = int'(bus.lock);
    end
    if (bus.lock && !lock_prev) begin
      lock_rises++; lock_gap = e - last_pv_edge; lock_pv = pv_cnt;
    end
    to_prev   = bus.timeout;
    lock_prev = bus.lock;
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; div_clk changes only between edges.
  task automatic drive_period(input int len, input int hi);
    #($urandom_range(0, 3));
    bus.div_clk = 1'b1;
    repeat (hi) @(negedge clk_in);
    bus.div_clk = 1'b0;
    repeat (len - hi) @(negedge clk_in);
  endtask

  task automatic drive_div7(input int n);
    for (int i = 0; i < n; i++) drive_period(DIV, $urandom_range(3, 4));
  endtask

  task automatic gap(input int n);
    bus.div_clk = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, int'(bus.period), 0);
    check({tag, "_high"}, int'(bus.high_cnt), 0);
    check({tag, "_pv"}, int'(bus.period_valid), 0);
    check({tag, "_lock"}, int'(bus.lock), 0);
    check({tag, "_err"}, int'(bus.err), 0);
    check({tag, "_timeout"}, int'(bus.timeout), 0);
    check({tag, "_state"}, int'(bus.state), int'(IDLE));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int base_pv, base_err, base_lock, base_to;
    bus.div_clk = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    #2 rst = 1'b1;
    @(negedge clk_in);

    // steady divide-by-7 from reset
    base_pv = pv_cnt; base_lock = lock_rises;
    drive_div7(10);
    check("s7_lock", int'(bus.lock), 1);
    check("s7_period", int'(bus.period), 7);
    check("s7_high_range", int'(bus.high_cnt >= 3 && bus.high_cnt <= 4), 1);
    check("s7_pv_count", pv_cnt - base_pv, 9);
    check("s7_lock_rises", lock_rises - base_lock, 1);
    check("s7_lock_after_pv", lock_pv - base_pv, 4);
    check("s7_lock_lag", lock_gap, 1);

    // one divide-by-8 period while locked
    base_err = err_cnt; base_lock = lock_rises;
    drive_period(8, 4);
    drive_div7(5);
    check("d8_err_count", err_cnt - base_err, 1);
    check("d8_err_period", err_period, 8);
    check("d8_err_lock", err_lock, 0);
    check("d8_relock", int'(bus.lock), 1);
    check("d8_relock_rises", lock_rises - base_lock, 1);

    // duty fault: period 7, one high cycle
    base_err = err_cnt; base_lock = lock_rises;
    drive_period(7, 1);
    drive_period(7, 3); drive_period(7, 3); drive_period(7, 3);
    drive_period(7, 1);
    drive_period(7, 3); drive_period(7, 3);
    check("duty_err_count", err_cnt - base_err, 1);
    check("duty_err_high", err_high, 1);
    check("duty_no_lock", int'(bus.lock), 0);
    check("duty_no_relock", lock_rises - base_lock, 0);

    // stuck low while locked
    drive_div7(5);
    check("stuck_pre_lock", int'(bus.lock), 1);
    base_to = to_cnt;
    gap(40);
    check("stuck_timeout", int'(bus.timeout), 1);
    check("stuck_lock", int'(bus.lock), 0);
    check("stuck_to_count", to_cnt - base_to, 1);
    check("stuck_to_delay", to_edge - last_pv_edge, 32);
    check("stuck_to_lock", to_lock, 0);
    base_pv = pv_cnt;
    drive_period(32, 16);
    check("clear_timeout", int'(bus.timeout), 0);
    check("clear_no_pv", pv_cnt - base_pv, 0);

    // rise coincident with counter reaching TIMEOUT
    base_to = to_cnt;
    drive_period(7, 3);
    check("coinc_period", last_pv_period, 32);
    check("coinc_pv", pv_cnt - base_pv, 1);
    check("coinc_timeout", int'(bus.timeout), 0);
    check("coinc_no_to", to_cnt - base_to, 0);

    // async reset mid-period while locked
    drive_div7(6);
    check("rst_pre_lock", int'(bus.lock), 1);
    bus.div_clk = 1'b1;
    repeat (2) @(negedge clk_in);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    bus.div_clk = 1'b0;
    repeat (3) @(negedge clk_in);
    #2 rst = 1'b1;
    @(negedge clk_in);
    drive_div7(5);
    check("rst_relock", int'(bus.lock), 1);

    // randomized periods, with occasional long gaps
    for (int n = 0; n < 150; n++) begin
      int sel, len;
      sel = $urandom_range(0, 99);
      if (sel < 60) begin
        drive_period(DIV, $urandom_range(3, 4));
      end else if (sel < 92) begin
        len = $urandom_range(5, 9);
        drive_period(len, $urandom_range(1, len - 1));
      end else if (sel < 96) begin
        drive_period(TIMEOUT, $urandom_range(1, TIMEOUT - 1));
      end else begin
        gap($urandom_range(30, 40));
      end
    end
    gap(5);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
